ps2_direction_decoder: RTL and testbench

Converts the raw PS/2 scan-code byte stream from the keyboard interface into held, per-player direction levels for the processor's movement inputs. Player 0 uses W/A/S/D; player 1 uses the extended arrow keys. Sits between the PS/2 interface (`ps2_key_pressed` strobe, `ps2_key_data` byte) and the processor wrapper's up/right/down/left direction inputs, which are currently driven by slide switches.

---
 rtl/game_pkg.sv | 48 ++++
 rtl/scan_code_map.sv | 30 +++
 rtl/ps2_direction_decoder.sv | 142 ++++++++++++++
 tb/tb_ps2_direction_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants for the PS/2 direction decoder: scan codes, parser states,
// direction bit positions and the opposing-direction cancel helper.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_BAT   = 8'hAA;

    localparam logic [7:0] SC_P0_UP    = 8'h1D;
    localparam logic [7:0] SC_P0_LEFT  = 8'h1C;
    localparam logic [7:0] SC_P0_DOWN  = 8'h1B;
    localparam logic [7:0] SC_P0_RIGHT = 8'h23;

    localparam logic [7:0] SC_P1_UP    = 8'h75;
    localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P1_DOWN  = 8'h72;
    localparam logic [7:0] SC_P1_RIGHT = 8'h74;

    localparam logic [1:0] DIR_UP    = 2'd3;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd0;

    // Bits to suppress when both members of an opposing pair are held.
    function automatic logic [3:0] opposing_mask(input logic [3:0] d);
        logic [3:0] m;
        m = 4'b0000;
        if (d[DIR_UP] && d[DIR_DOWN]) begin
            m[DIR_UP]   = 1'b1;
            m[DIR_DOWN] = 1'b1;
        end
        if (d[DIR_LEFT] && d[DIR_RIGHT]) begin
            m[DIR_LEFT]  = 1'b1;
            m[DIR_RIGHT] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/scan_code_map.sv
// Maps an {extended, scan code} pair to a player and direction bit.
// Keypad codes without the E0 prefix deliberately miss.
module scan_code_map
    import game_pkg::*;
(
    input  logic       i_ext,
    input  logic [7:0] i_code,
    output logic       o_hit,
    output logic       o_player,
    output logic [1:0] o_dir_idx
);

    always_comb begin
        o_hit     = 1'b1;
        o_player  = 1'b0;
        o_dir_idx = DIR_LEFT;
        case ({i_ext, i_code})
            {1'b0, SC_P0_UP}:    o_dir_idx = DIR_UP;
            {1'b0, SC_P0_LEFT}:  o_dir_idx = DIR_LEFT;
            {1'b0, SC_P0_DOWN}:  o_dir_idx = DIR_DOWN;
            {1'b0, SC_P0_RIGHT}: o_dir_idx = DIR_RIGHT;
            {1'b1, SC_P1_UP}:    begin o_player = 1'b1; o_dir_idx = DIR_UP;    end
            {1'b1, SC_P1_LEFT}:  begin o_player = 1'b1; o_dir_idx = DIR_LEFT;  end
            {1'b1, SC_P1_DOWN}:  begin o_player = 1'b1; o_dir_idx = DIR_DOWN;  end
            {1'b1, SC_P1_RIGHT}: begin o_player = 1'b1; o_dir_idx = DIR_RIGHT; end
            default:             o_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Turns the PS/2 scan-code stream into held per-player direction levels
// (player 0 on WASD-style codes, player 1 on extended arrows).
module ps2_direction_decoder
    import game_pkg::*;
#(
    parameter int PREFIX_TIMEOUT  = 50000,
    parameter bit CANCEL_OPPOSING = 1'b1
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    output logic [3:0] p0_dir,
    output logic [3:0] p1_dir,
    output logic       key_event,
    output logic       seq_error
);

    localparam logic [15:0] TMO_LAST = 16'(PREFIX_TIMEOUT - 1);

    state_t      r_state;
    logic [2:0]  r_skip_cnt;
    logic [15:0] r_tmo_cnt;
    logic [7:0]  r_held;
    logic [3:0]  r_p0_dir;
    logic [3:0]  r_p1_dir;
    logic        r_key_event;
    logic        r_seq_error;

    logic        w_ext;
    logic        w_hit;
    logic        w_player;
    logic [1:0]  w_dir_idx;
    logic [7:0]  w_held_nxt;
    logic [3:0]  w_p0_nxt;
    logic [3:0]  w_p1_nxt;

    assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

    scan_code_map u_map (
        .i_ext     (w_ext),
        .i_code    (ps2_key_data),
        .o_hit     (w_hit),
        .o_player  (w_player),
        .o_dir_idx (w_dir_idx)
    );

    // Prefix bytes are never mapped codes, so a hit alone identifies a make/break.
    always_comb begin
        w_held_nxt = r_held;
        if (ps2_key_pressed) begin
            case (r_state)
                ST_IDLE: begin
                    if (ps2_key_data == SC_BAT)
                        w_held_nxt = 8'h00;
                    else if (w_hit)
                        w_held_nxt[{w_player, w_dir_idx}] = 1'b1;
                end
                ST_EXT: begin
                    if (w_hit)
                        w_held_nxt[{w_player, w_dir_idx}] = 1'b1;
                end
                ST_BRK, ST_EXT_BRK: begin
                    if (w_hit)
                        w_held_nxt[{w_player, w_dir_idx}] = 1'b0;
                end
                default: w_held_nxt = r_held;
            endcase
        end
    end

    always_comb begin
        w_p0_nxt = w_held_nxt[3:0];
        w_p1_nxt = w_held_nxt[7:4];
        if (CANCEL_OPPOSING) begin
            w_p0_nxt = w_held_nxt[3:0] & ~opposing_mask(w_held_nxt[3:0]);
            w_p1_nxt = w_held_nxt[7:4] & ~opposing_mask(w_held_nxt[7:4]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_skip_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_held      <= '0;
            r_p0_dir    <= '0;
            r_p1_dir    <= '0;
            r_key_event <= 1'b0;
            r_seq_error <= 1'b0;
        end else begin
            r_held      <= w_held_nxt;
            r_p0_dir    <= w_p0_nxt;
            r_p1_dir    <= w_p1_nxt;
            r_key_event <= (w_held_nxt != r_held);
            if (ps2_key_pressed) begin
                // A strobe always beats a timeout landing in the same cycle.
                r_tmo_cnt <= '0;
                case (r_state)
                    ST_IDLE: begin
                        if (ps2_key_data == SC_EXT)
                            r_state <= ST_EXT;
                        else if (ps2_key_data == SC_BRK)
                            r_state <= ST_BRK;
                        else if (ps2_key_data == SC_PAUSE) begin
                            r_state    <= ST_SKIP;
                            r_skip_cnt <= 3'd7;
                        end
                    end
                    ST_EXT: begin
                        if (ps2_key_data == SC_BRK)
                            r_state <= ST_EXT_BRK;
                        else if (ps2_key_data != SC_EXT)
                            r_state <= ST_IDLE;
                    end
                    ST_BRK, ST_EXT_BRK: r_state <= ST_IDLE;
                    ST_SKIP: begin
                        r_skip_cnt <= r_skip_cnt - 3'd1;
                        if (r_skip_cnt == 3'd1)
                            r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end else if (r_state != ST_IDLE) begin
                if (r_tmo_cnt >= TMO_LAST) begin
                    r_state     <= ST_IDLE;
                    r_tmo_cnt   <= '0;
                    r_skip_cnt  <= '0;
                    r_seq_error <= 1'b1;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 16'd1;
                end
            end
        end
    end

    assign p0_dir    = r_p0_dir;
    assign p1_dir    = r_p1_dir;
    assign key_event = r_key_event;
    assign seq_error = r_seq_error;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder with hand-computed expectations.
module tb_ps2_direction_decoder;
    import game_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_key_pressed = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic [3:0] p0_dir, p1_dir;
    logic       key_event, seq_error;

    int tests = 0;
    int fails = 0;

    ps2_direction_decoder dut (
        .clock           (clock),
        .resetn          (resetn),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .p0_dir          (p0_dir),
        .p1_dir          (p1_dir),
        .key_event       (key_event),
        .seq_error       (seq_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns at the negedge where the result is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        // Reset state
        idle(3);
        check("rst_p0", {4'h0, p0_dir}, 8'h00);
        check("rst_p1", {4'h0, p1_dir}, 8'h00);
        check("rst_evt", {7'h0, key_event}, 8'h00);
        check("rst_err", {7'h0, seq_error}, 8'h00);
        resetn = 1'b1;
        idle(1);

        // Make / break of player 0 up
        send(8'h1D);
        check("up_make_p0", {4'h0, p0_dir}, 8'h08);
        check("up_make_evt", {7'h0, key_event}, 8'h01);
        idle(1);
        check("evt_one_cycle", {7'h0, key_event}, 8'h00);
        send(8'hF0);
        check("brk_prefix_p0", {4'h0, p0_dir}, 8'h08);
        check("brk_prefix_evt", {7'h0, key_event}, 8'h00);
        send(8'h1D);
        check("up_brk_p0", {4'h0, p0_dir}, 8'h00);
        check("up_brk_evt", {7'h0, key_event}, 8'h01);

        // Extended right arrow, then an unprefixed keypad 74
        send(8'hE0);
        send(8'h74);
        check("p1_right", {4'h0, p1_dir}, 8'h04);
        check("p1_right_evt", {7'h0, key_event}, 8'h01);
        send(8'h74);
        check("keypad_p1", {4'h0, p1_dir}, 8'h04);
        check("keypad_p0", {4'h0, p0_dir}, 8'h00);
        check("keypad_evt", {7'h0, key_event}, 8'h00);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("p1_release", {4'h0, p1_dir}, 8'h00);

        // Opposing up+down cancel
        send(8'h1D);
        send(8'h1B);
        check("cancel_p0", {4'h0, p0_dir}, 8'h00);
        check("cancel_held", {4'h0, dut.r_held[3:0]}, 8'h0A);
        send(8'hF0); send(8'h1B);
        check("uncancel_p0", {4'h0, p0_dir}, 8'h08);
        send(8'hF0); send(8'h1D);
        check("clear_p0", {4'h0, p0_dir}, 8'h00);

        // Pause sequence is swallowed
        for (int i = 0; i < 8; i++) begin
            send(pause_seq[i]);
            check($sformatf("pause_p0_%0d", i), {4'h0, p0_dir}, 8'h00);
            check($sformatf("pause_evt_%0d", i), {7'h0, key_event}, 8'h00);
        end
        send(8'h1C);
        check("after_pause_p0", {4'h0, p0_dir}, 8'h01);
        send(8'h1C);
        check("typematic_p0", {4'h0, p0_dir}, 8'h01);
        check("typematic_evt", {7'h0, key_event}, 8'h00);
        send(8'hF0); send(8'h1C);
        check("left_release", {4'h0, p0_dir}, 8'h00);

        // Back-to-back strobes: 23, E0, 6B on consecutive cycles
        @(negedge clock);
        ps2_key_pressed = 1'b1; ps2_key_data = 8'h23;
        @(negedge clock);
        ps2_key_data = 8'hE0;
        @(negedge clock);
        ps2_key_data = 8'h6B;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        check("b2b_p0", {4'h0, p0_dir}, 8'h04);
        check("b2b_p1", {4'h0, p1_dir}, 8'h01);
        send(8'hAA);
        check("bat_p0", {4'h0, p0_dir}, 8'h00);
        check("bat_p1", {4'h0, p1_dir}, 8'h00);

        // Prefix timeout
        send(8'hE0);
        idle(49999);
        check("tmo_not_yet", {7'h0, seq_error}, 8'h00);
        idle(1);
        check("tmo_err", {7'h0, seq_error}, 8'h01);
        check("tmo_idle", {5'h0, dut.r_state}, {5'h0, ST_IDLE});
        send(8'h23);
        check("tmo_then_right", {4'h0, p0_dir}, 8'h04);
        check("tmo_sticky", {7'h0, seq_error}, 8'h01);
        send(8'hF0); send(8'h23);

        // Reset mid-sequence: the following 75 is parsed from IDLE (keypad)
        send(8'hE0); send(8'hF0);
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        check("midrst_err", {7'h0, seq_error}, 8'h00);
        resetn = 1'b1;
        send(8'h75);
        check("midrst_p1", {4'h0, p1_dir}, 8'h00);
        check("midrst_p0", {4'h0, p0_dir}, 8'h00);
        check("midrst_evt", {7'h0, key_event}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
